// File: rtl/coin_scheduler.sv
// coin_scheduler: loads per-level coin positions from the coin ROM, re-arms the coin bank and tracks collection.
// Optional COIN_SCORE_EN adds a saturating 16-bit score output.
//
// state     | meaning
// S_IDLE    | after reset, waiting for the first level_load
// S_LOAD    | walking slots 0..NUM_COINS-1 through the ROM, latching positions one cycle later
// S_REFRESH | one-cycle re-arm pulse to every coin
// S_ACTIVE  | play: counting remaining coins, pulsing on new collections
// S_DONE    | every valid coin collected
module coin_scheduler #(
    parameter int NUM_COINS = 8,
    parameter int LEVEL_W   = 3
) (
    input  logic                                  frame_clk,
    input  logic                                  Reset_n,
    input  logic                                  level_load,
    input  logic [LEVEL_W-1:0]                    level,
    input  logic                                  player_death,
    output logic [LEVEL_W+$clog2(NUM_COINS)-1:0]  rom_addr,
    input  logic [19:0]                           rom_data,
    output logic [10*NUM_COINS-1:0]               coin_x,
    output logic [10*NUM_COINS-1:0]               coin_y,
    output logic                                  refresh,
    input  logic [NUM_COINS-1:0]                  collected,
    output logic [4:0]                            coins_remaining,
    output logic                                  collect_pulse,
    output logic                                  all_collected,
    output logic                                  busy
`ifdef COIN_SCORE_EN
    ,
    output logic [15:0]                           score
`endif
);

    localparam int SW = $clog2(NUM_COINS);
    localparam logic [SW:0] CNT_ONE  = {{SW{1'b0}}, 1'b1};
    localparam logic [SW:0] CNT_LAST = {1'b1, {SW{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REFRESH, S_ACTIVE, S_DONE} state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SW:0]            r_cnt;
    logic [LEVEL_W-1:0]     r_lvl;
    logic [NUM_COINS-1:0]   r_valid;
    logic [NUM_COINS-1:0]   r_prev;
    logic [10*NUM_COINS-1:0] r_x;
    logic [10*NUM_COINS-1:0] r_y;
    logic [4:0]             r_remaining;
    logic                   r_pulse;
    logic                   r_first;
    logic [NUM_COINS-1:0]   w_edges;
    logic [4:0]             w_pop_rem;
    logic [4:0]             w_pop_edge;
    logic [SW-1:0]          w_slot;

    assign w_edges = collected & ~r_prev & r_valid;
    // ROM data arriving now belongs to the slot addressed in the previous cycle
    assign w_slot  = r_cnt[SW-1:0] - SW'(1);

    always_comb begin
        w_pop_rem  = '0;
        w_pop_edge = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            w_pop_rem  = w_pop_rem + 5'(r_valid[i] & ~collected[i]);
            w_pop_edge = w_pop_edge + 5'(w_edges[i]);
        end
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (level_load) begin
            w_next = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD:    if (r_cnt == CNT_LAST) w_next = S_REFRESH;
                S_REFRESH: w_next = S_ACTIVE;
                S_ACTIVE: begin
                    if (player_death)                        w_next = S_REFRESH;
                    else if (!r_first && r_remaining == '0)  w_next = S_DONE;
                end
                S_DONE:    if (player_death) w_next = S_REFRESH;
                default:   ;
            endcase
        end
    end

    always_comb begin
        rom_addr      = '0;
        refresh       = 1'b0;
        busy          = 1'b0;
        all_collected = 1'b0;
        case (r_state)
            S_LOAD: begin
                busy = 1'b1;
                if (!r_cnt[SW]) rom_addr = {r_lvl, r_cnt[SW-1:0]};
            end
            S_REFRESH: begin
                busy    = 1'b1;
                refresh = 1'b1;
            end
            S_DONE:  all_collected = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt       <= '0;
            r_lvl       <= '0;
            r_valid     <= '0;
            r_prev      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_remaining <= '0;
            r_pulse     <= 1'b0;
            r_first     <= 1'b0;
        end else if (level_load) begin
            r_lvl       <= level;
            r_cnt       <= '0;
            r_valid     <= '0;
            r_prev      <= '0;
            r_remaining <= '0;
            r_pulse     <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            r_first <= (r_state == S_REFRESH);
            r_pulse <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (r_cnt != '0) begin
                        r_x[10*w_slot +: 10] <= rom_data[19:10];
                        r_y[10*w_slot +: 10] <= rom_data[9:0];
                        r_valid[w_slot]      <= (rom_data != '0);
                    end
                end
                S_REFRESH: r_prev <= '0;
                S_ACTIVE: begin
                    r_remaining <= w_pop_rem;
                    r_prev      <= collected;
                    r_pulse     <= !player_death && (w_edges != '0);
                end
                S_DONE: begin
                    r_remaining <= w_pop_rem;
                    r_prev      <= collected;
                end
                default: ;
            endcase
        end
    end

    assign coin_x          = r_x;
    assign coin_y          = r_y;
    assign coins_remaining = r_remaining;
    assign collect_pulse   = r_pulse;

`ifdef COIN_SCORE_EN
    logic [15:0] r_score;
    logic [15:0] r_earned;
    logic [7:0]  w_gain;
    logic [16:0] w_score_sum;
    logic [16:0] w_earned_sum;

    assign w_gain       = {w_pop_edge, 3'b000} + {2'b00, w_pop_edge, 1'b0};
    assign w_score_sum  = {1'b0, r_score} + {9'b0, w_gain};
    assign w_earned_sum = {1'b0, r_earned} + {9'b0, w_gain};

    // r_earned is what a death takes back: points gained since the last re-arm
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_score  <= '0;
            r_earned <= '0;
        end else if (level_load) begin
            r_earned <= '0;
        end else if (player_death && (r_state == S_ACTIVE || r_state == S_DONE)) begin
            r_score  <= (r_score > r_earned) ? (r_score - r_earned) : '0;
            r_earned <= '0;
        end else if (r_state == S_ACTIVE) begin
            r_score  <= w_score_sum[16]  ? 16'hFFFF : w_score_sum[15:0];
            r_earned <= w_earned_sum[16] ? 16'hFFFF : w_earned_sum[15:0];
        end else if (r_state == S_REFRESH) begin
            r_earned <= '0;
        end
    end

    assign score = r_score;
`endif

endmodule
